// File: rtl/adder_tree_pkg.sv
// Shared defaults and sizing helpers for the pipelined adder tree.
// Latency: n/a (constants and elaboration-time functions only).
// Backpressure: n/a.
package adder_tree_pkg;

    localparam int ADDER_TREE_WIDTH  = 32;
    localparam int ADDER_TREE_INPUTS = 8;

    // Operand count after zero padding up to the next power of two.
    function automatic int pow2_ceil(int n);
        int p;
        p = 1;
        while (p < n) p = p << 1;
        return p;
    endfunction

    // Number of sums held at tree level s (level 0 is the padded operand set).
    function automatic int level_width(int s, int n = ADDER_TREE_INPUTS);
        return pow2_ceil(n) >> s;
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One tree level: sums adjacent operand pairs into IN_NUM/2 registers.
// Latency: 1 cycle, result wraps modulo 2**WIDTH.
// Backpressure: none, a new operand set is taken every cycle.
module adder_tree_level
    import adder_tree_pkg::*;
#(
    parameter int WIDTH  = ADDER_TREE_WIDTH,
    parameter int IN_NUM = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [IN_NUM-1:0][WIDTH-1:0]       in_dat,
    output logic [IN_NUM/2-1:0][WIDTH-1:0]     sum_dat
);

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_dat <= '0;
        end else begin
            for (int k = 0; k < IN_NUM / 2; k++) begin
                sum_dat[k] <= in_dat[2*k] + in_dat[2*k+1];
            end
        end
    end

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined binary reduction tree summing INPUT_NUM operands; optional valid tracking under ADDER_TREE_VALID_EN.
// Latency: STAGE_NUM cycles, one register per tree level, no combinational path from indata to res.
// Backpressure: none, one operand vector accepted per clock with no stall.
module pipelined_adder_tree
    import adder_tree_pkg::*;
#(
    parameter int WIDTH     = ADDER_TREE_WIDTH,
    parameter int INPUT_NUM = ADDER_TREE_INPUTS,
    parameter int STAGE_NUM = $clog2(INPUT_NUM)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [INPUT_NUM-1:0][WIDTH-1:0] indata,
`ifdef ADDER_TREE_VALID_EN
    input  logic                           in_valid,
    output logic                           out_valid,
`endif
    output logic [WIDTH-1:0]               res
);

    localparam int P = pow2_ceil(INPUT_NUM);

    // Heap-ordered tree: node i has children 2i and 2i+1, leaves at P..2P-1, root at 1.
    logic [2*P-1:1][WIDTH-1:0] node;

    generate
        if (INPUT_NUM == P) begin : g_no_pad
            assign node[2*P-1:P] = indata;
        end else begin : g_pad
            assign node[P+INPUT_NUM-1:P] = indata;
            assign node[2*P-1:P+INPUT_NUM] = '0;
        end
    endgenerate

    for (genvar s = 1; s <= STAGE_NUM; s++) begin : g_level
        localparam int NIN  = level_width(s - 1, INPUT_NUM);
        localparam int NOUT = level_width(s, INPUT_NUM);

        adder_tree_level #(
            .WIDTH  (WIDTH),
            .IN_NUM (NIN)
        ) u_level (
            .clk     (clk),
            .rst     (rst),
            .in_dat  (node[2*NIN-1:NIN]),
            .sum_dat (node[2*NOUT-1:NOUT])
        );
    end

    assign res = node[1];

`ifdef ADDER_TREE_VALID_EN
    logic [STAGE_NUM-1:0] vld_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= in_valid;
            for (int i = 1; i < STAGE_NUM; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
        end
    end

    assign out_valid = vld_sr[STAGE_NUM-1];
`endif

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Bench for pipelined_adder_tree: fixed vector table, directed latency/reset sequences and random traffic.
module tb_pipelined_adder_tree;

    localparam int W     = 32;
    localparam int N     = 8;
    localparam int S     = 3;
    localparam int HMAX  = 2048;

    typedef logic [N-1:0][W-1:0] vec_t;

    typedef struct {
        string      name;
        vec_t       vec;
        logic [W-1:0] exp;
    } tvec_t;

    logic         clk = 1'b0;
    logic         rst;
    vec_t         indata;
    logic [W-1:0] res;
`ifdef ADDER_TREE_VALID_EN
    logic         in_valid;
    logic         out_valid;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int n_edge = 0;

    logic hist_rst [HMAX];
    logic hist_iv  [HMAX];
    vec_t hist_vec [HMAX];

    always #5 clk = ~clk;

    pipelined_adder_tree #(
        .WIDTH     (W),
        .INPUT_NUM (N),
        .STAGE_NUM (S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .indata    (indata),
`ifdef ADDER_TREE_VALID_EN
        .in_valid  (in_valid),
        .out_valid (out_valid),
`endif
        .res       (res)
    );

    function automatic logic [W-1:0] vec_sum(vec_t v);
        longint unsigned acc = 0;
        for (int i = 0; i < N; i++) acc += v[i];
        return acc[W-1:0];
    endfunction

    // Expected state after edge e: zero if any reset lands inside the S-edge window, else sum of the oldest vector.
    function automatic logic window_clean(int e);
        if (e - S + 1 < 0) return 1'b0;
        for (int k = e - S + 1; k <= e; k++) if (hist_rst[k]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [W-1:0] model_res(int e);
        if (!window_clean(e)) return '0;
        return vec_sum(hist_vec[e - S + 1]);
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: res=0x%08h expected 0x%08h (edge %0d)", name, act, exp, n_edge);
        end
    endtask

    task automatic step(input logic r, input vec_t v, input logic iv, input string name);
        rst    = r;
        indata = v;
`ifdef ADDER_TREE_VALID_EN
        in_valid = iv;
`endif
        @(posedge clk);
        if (n_edge < HMAX) begin
            hist_rst[n_edge] = r;
            hist_vec[n_edge] = v;
            hist_iv[n_edge]  = iv;
        end
        n_edge++;
        #1;
        if (n_edge <= HMAX) begin
            check(name, res, model_res(n_edge - 1));
`ifdef ADDER_TREE_VALID_EN
            check({name, "_vld"}, {31'd0, out_valid},
                  {31'd0, window_clean(n_edge - 1) && hist_iv[n_edge - S]});
`endif
        end
    endtask

    function automatic vec_t fill(logic [W-1:0] x);
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = x;
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = $urandom;
        return v;
    endfunction

    tvec_t tbl [5];

    initial begin
        tbl[0].name = "single_op";  tbl[0].vec = '0; tbl[0].vec[0] = 32'd32; tbl[0].exp = 32'd32;
        tbl[1].name = "full_sum";
        for (int i = 0; i < N; i++) tbl[1].vec[i] = W'(i + 1);
        tbl[1].exp = 32'd36;
        tbl[2].name = "wrap_ff_1";  tbl[2].vec = '0; tbl[2].vec[0] = 32'hFFFF_FFFF; tbl[2].vec[1] = 32'd1;
        tbl[2].exp = 32'd0;
        tbl[3].name = "wrap_8x80";  tbl[3].vec = fill(32'h8000_0000); tbl[3].exp = 32'd0;
        tbl[4].name = "all_ones";   tbl[4].vec = fill(32'd1); tbl[4].exp = 32'd8;

        // Reset held for three edges with random data, then one clean edge.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, rand_vec(), 1'b1, "reset_hold");
            check("reset_zero", res, 32'd0);
        end
        step(1'b0, '0, 1'b0, "post_reset");
        check("post_reset_zero", res, 32'd0);

        // Table: each vector held S+2 edges; result must land on edge S and stay.
        foreach (tbl[t]) begin
            step(1'b1, '0, 1'b0, "tbl_reset");
            for (int k = 1; k <= S + 2; k++) begin
                step(1'b0, tbl[t].vec, 1'b0, tbl[t].name);
                if (k < S) check({tbl[t].name, "_early"}, res, 32'd0);
                else       check({tbl[t].name, "_const"}, res, tbl[t].exp);
            end
        end

        // Back-to-back vectors emerge on consecutive cycles.
        step(1'b0, fill(32'd1), 1'b1, "pipe_a");
        step(1'b0, fill(32'd2), 1'b0, "pipe_b");
        step(1'b0, fill(32'd3), 1'b0, "pipe_c");
        check("pipe_8", res, 32'd8);
        step(1'b0, '0, 1'b0, "pipe_d");
        check("pipe_16", res, 32'd16);
        step(1'b0, '0, 1'b0, "pipe_e");
        check("pipe_24", res, 32'd24);

        // Mid-stream reset: in-flight 8/16/24 must never appear.
        step(1'b0, fill(32'd1), 1'b1, "mid_a");
        step(1'b0, fill(32'd2), 1'b1, "mid_b");
        step(1'b1, fill(32'd3), 1'b1, "mid_rst");
        check("mid_rst_zero", res, 32'd0);
        for (int k = 0; k < S; k++) begin
            step(1'b0, '0, 1'b0, "mid_drain");
            check("mid_drain_zero", res, 32'd0);
        end

        // Valid pulse every third cycle.
        for (int k = 0; k < 18; k++) step(1'b0, rand_vec(), (k % 3) == 0, "vld_pulse");

        // Random traffic with sparse resets.
        for (int k = 0; k < 300; k++)
            step(($urandom_range(0, 39) == 0), rand_vec(), 1'($urandom), "random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
